// File: rtl/user_ddr_arbiter.sv
// rtl/user_ddr_arbiter.sv - round-robin read/write arbiter for four stream ports onto one DDR port
// Writes are granted as locked two-beat bursts; each read grant leaves a port tag that routes its two returned data beats.
module user_ddr_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int TAG_DEPTH = 16
) (
   input  logic                     i_ddr_clk,
   input  logic                     i_rst,
   input  logic [NUM_PORTS-1:0]     i_rd_req,
   output logic [NUM_PORTS-1:0]     o_rd_ack,
   input  logic [32*NUM_PORTS-1:0]  i_rd_addr,
   output logic [NUM_PORTS-1:0]     o_rd_data_valid,
   output logic [255:0]             o_rd_data,
   input  logic [NUM_PORTS-1:0]     i_wr_req,
   output logic [NUM_PORTS-1:0]     o_wr_ack,
   input  logic [32*NUM_PORTS-1:0]  i_wr_addr,
   input  logic [256*NUM_PORTS-1:0] i_wr_data,
   input  logic [32*NUM_PORTS-1:0]  i_wr_be_n,
   output logic                     o_ddr_rd_req,
   input  logic                     i_ddr_rd_ack,
   output logic [31:0]              o_ddr_rd_addr,
   input  logic                     i_ddr_rd_data_valid,
   input  logic [255:0]             i_ddr_rd_data,
   output logic                     o_ddr_wr_req,
   input  logic                     i_ddr_wr_ack,
   output logic [31:0]              o_ddr_wr_addr,
   output logic [255:0]             o_ddr_wr_data,
   output logic [31:0]              o_ddr_wr_be_n,
   output logic                     o_tag_err
);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = $clog2(TAG_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAG_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);
   localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] RD_GNT    = 2'd1;
   localparam logic [1:0] WR_FIRST  = 2'd2;
   localparam logic [1:0] WR_SECOND = 2'd3;

   logic [1:0]           state, state_nxt;
   logic [1:0]           gnt, gnt_nxt;
   logic [NUM_PORTS-1:0] eligible;
   logic                 found;
   logic [1:0]           pick, idx;
   logic [NUM_PORTS-1:0] gnt_onehot;

   logic [1:0]           tag_mem [TAG_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [CNT_W-1:0]     tag_cnt;
   logic                 beat;
   logic                 tag_push, tag_pop, data_ok;
   logic [1:0]           head;

   logic [31:0]          rd_addr_a [NUM_PORTS];
   logic [31:0]          wr_addr_a [NUM_PORTS];
   logic [31:0]          wr_be_a   [NUM_PORTS];
   logic [255:0]         wr_data_a [NUM_PORTS];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign rd_addr_a[p] = i_rd_addr[32*p +: 32];
      assign wr_addr_a[p] = i_wr_addr[32*p +: 32];
      assign wr_be_a[p]   = i_wr_be_n[32*p +: 32];
      assign wr_data_a[p] = i_wr_data[256*p +: 256];
   end

   // Search starts one past the last grant; gnt resets to 3 so port 0 is first.
   always_comb begin
      eligible = i_wr_req | (i_rd_req & {NUM_PORTS{tag_cnt < CNT_FULL}});
      found    = 1'b0;
      pick     = gnt;
      idx      = gnt;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = gnt + 2'(k);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      case (state)
         IDLE: begin
            if (found) begin
               gnt_nxt   = pick;
               state_nxt = i_wr_req[pick] ? WR_FIRST : RD_GNT;
            end
         end
         RD_GNT:    if (i_ddr_rd_ack) state_nxt = IDLE;
         WR_FIRST:  if (i_ddr_wr_ack) state_nxt = WR_SECOND;
         WR_SECOND: if (i_ddr_wr_ack) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   assign o_ddr_rd_req  = (state == RD_GNT);
   assign o_ddr_wr_req  = (state == WR_FIRST) || (state == WR_SECOND);
   assign gnt_onehot    = ONE_HOT0 << gnt;
   assign o_rd_ack      = (o_ddr_rd_req && i_ddr_rd_ack) ? gnt_onehot : '0;
   assign o_wr_ack      = (o_ddr_wr_req && i_ddr_wr_ack) ? gnt_onehot : '0;
   assign o_ddr_rd_addr = rd_addr_a[gnt];
   assign o_ddr_wr_addr = wr_addr_a[gnt];
   assign o_ddr_wr_data = wr_data_a[gnt];
   assign o_ddr_wr_be_n = wr_be_a[gnt];

   // Beats arriving with no outstanding tag are dropped rather than routed.
   assign tag_push        = o_ddr_rd_req && i_ddr_rd_ack;
   assign data_ok         = i_ddr_rd_data_valid && (tag_cnt != '0);
   assign tag_pop         = data_ok && beat;
   assign head            = tag_mem[rd_ptr];
   assign o_rd_data_valid = data_ok ? (ONE_HOT0 << head) : '0;
   assign o_rd_data       = i_ddr_rd_data;

   always_ff @(posedge i_ddr_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         gnt       <= 2'd3;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         tag_cnt   <= '0;
         beat      <= 1'b0;
         o_tag_err <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         if (tag_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (tag_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         if (tag_push && !tag_pop)      tag_cnt <= tag_cnt + 1'b1;
         else if (!tag_push && tag_pop) tag_cnt <= tag_cnt - 1'b1;
         if (data_ok) beat <= ~beat;
         if (i_ddr_rd_data_valid && (tag_cnt == '0)) o_tag_err <= 1'b1;
      end
   end

   always_ff @(posedge i_ddr_clk) begin
      if (tag_push) tag_mem[wr_ptr] <= gnt;
   end
endmodule

// File: tb/tb_user_ddr_arbiter.sv
// tb/tb_user_ddr_arbiter.sv - scoreboard bench for user_ddr_arbiter
// A transaction-level model predicts each cycle's DDR-side activity; a negedge monitor compares.
module tb_user_ddr_arbiter;
   logic          i_ddr_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [3:0]    i_rd_req = '0;
   logic [3:0]    o_rd_ack;
   logic [127:0]  i_rd_addr = '0;
   logic [3:0]    o_rd_data_valid;
   logic [255:0]  o_rd_data;
   logic [3:0]    i_wr_req = '0;
   logic [3:0]    o_wr_ack;
   logic [127:0]  i_wr_addr = '0;
   logic [1023:0] i_wr_data = '0;
   logic [127:0]  i_wr_be_n = '0;
   logic          o_ddr_rd_req;
   logic          i_ddr_rd_ack = 1'b0;
   logic [31:0]   o_ddr_rd_addr;
   logic          i_ddr_rd_data_valid = 1'b0;
   logic [255:0]  i_ddr_rd_data = '0;
   logic          o_ddr_wr_req;
   logic          i_ddr_wr_ack = 1'b0;
   logic [31:0]   o_ddr_wr_addr;
   logic [255:0]  o_ddr_wr_data;
   logic [31:0]   o_ddr_wr_be_n;
   logic          o_tag_err;

   user_ddr_arbiter #(.NUM_PORTS(4), .TAG_DEPTH(16)) dut (
      .i_ddr_clk(i_ddr_clk), .i_rst(i_rst),
      .i_rd_req(i_rd_req), .o_rd_ack(o_rd_ack), .i_rd_addr(i_rd_addr),
      .o_rd_data_valid(o_rd_data_valid), .o_rd_data(o_rd_data),
      .i_wr_req(i_wr_req), .o_wr_ack(o_wr_ack), .i_wr_addr(i_wr_addr),
      .i_wr_data(i_wr_data), .i_wr_be_n(i_wr_be_n),
      .o_ddr_rd_req(o_ddr_rd_req), .i_ddr_rd_ack(i_ddr_rd_ack), .o_ddr_rd_addr(o_ddr_rd_addr),
      .i_ddr_rd_data_valid(i_ddr_rd_data_valid), .i_ddr_rd_data(i_ddr_rd_data),
      .o_ddr_wr_req(o_ddr_wr_req), .i_ddr_wr_ack(i_ddr_wr_ack), .o_ddr_wr_addr(o_ddr_wr_addr),
      .o_ddr_wr_data(o_ddr_wr_data), .o_ddr_wr_be_n(o_ddr_wr_be_n), .o_tag_err(o_tag_err)
   );

   always #5 i_ddr_clk = ~i_ddr_clk;

   typedef struct packed {
      int           cyc;
      logic         rd_req;
      logic         wr_req;
      logic         dv;
      logic         tag_err;
      logic [3:0]   rd_ack;
      logic [3:0]   wr_ack;
      logic [3:0]   rd_valid;
      logic [31:0]  rd_addr;
      logic [31:0]  wr_addr;
      logic [31:0]  be_n;
      logic [255:0] wr_data;
      logic [255:0] rd_data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   grant_log[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   // Model: current transaction (0 none, 1 read, 2 write), last granted port, outstanding read tags.
   int   m_kind, m_port, m_last, m_beats;
   bit   m_second, m_err;
   int   tags[$];

   always @(posedge i_ddr_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_kind = 0; m_port = 0; m_last = 3; m_beats = 0;
      m_second = 0; m_err = 0;
      tags.delete();
   endtask

   task automatic drive_cycle(input logic [3:0] rr, input logic [3:0] wr,
                              input logic ra, input logic wa, input logic dv);
      exp_t e;
      bit   found;
      bit   push;
      int   p;
      @(posedge i_ddr_clk);
      #1;
      i_rd_req = rr; i_wr_req = wr;
      i_ddr_rd_ack = ra; i_ddr_wr_ack = wa; i_ddr_rd_data_valid = dv;
      for (int k = 0; k < 4; k++) begin
         i_rd_addr[32*k +: 32] = $urandom();
         i_wr_addr[32*k +: 32] = $urandom();
         i_wr_be_n[32*k +: 32] = $urandom();
      end
      for (int k = 0; k < 32; k++) i_wr_data[32*k +: 32] = $urandom();
      for (int k = 0; k < 8; k++)  i_ddr_rd_data[32*k +: 32] = $urandom();

      e = '0;
      e.cyc = cyc; e.dv = dv; e.tag_err = m_err; e.rd_data = i_ddr_rd_data;
      found = 0; push = 0;
      if (m_kind == 1) begin
         e.rd_req = 1'b1;
         e.rd_addr = i_rd_addr[32*m_port +: 32];
         if (ra) begin e.rd_ack[m_port] = 1'b1; push = 1; m_kind = 0; end
      end else if (m_kind == 2) begin
         e.wr_req = 1'b1;
         e.wr_addr = i_wr_addr[32*m_port +: 32];
         e.be_n = i_wr_be_n[32*m_port +: 32];
         e.wr_data = i_wr_data[256*m_port +: 256];
         if (wa) begin
            e.wr_ack[m_port] = 1'b1;
            m_beats--;
            if (m_beats == 0) m_kind = 0;
         end
      end else begin
         for (int k = 1; k <= 4; k++) begin
            p = (m_last + k) % 4;
            if (!found && (wr[p] || (rr[p] && tags.size() < 16))) begin
               found = 1; m_port = p; m_last = p; m_beats = 2;
               m_kind = wr[p] ? 2 : 1;
            end
         end
      end
      if (dv) begin
         if (tags.size() == 0) m_err = 1;
         else begin
            e.rd_valid[tags[0]] = 1'b1;
            if (m_second) void'(tags.pop_front());
            m_second = !m_second;
         end
      end
      if (push) tags.push_back(m_port);
      if (e.rd_req || e.wr_req || dv) exp_q.push_back(e);
   endtask

   task automatic settle();
      repeat (4) drive_cycle(4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic drain();
      for (int t = 0; t < 40; t++) begin
         if (tags.size() == 0) break;
         drive_cycle(4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
      end
   endtask

   always @(negedge i_ddr_clk) begin
      if (!i_rst) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missed_output", 256'(0), 256'(1));
            void'(exp_q.pop_front());
         end
         for (int k = 0; k < 4; k++) if (o_rd_ack[k]) grant_log.push_back(k);
         if (o_ddr_rd_req || o_ddr_wr_req || i_ddr_rd_data_valid ||
             (|o_rd_ack) || (|o_wr_ack) || (|o_rd_data_valid)) begin
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
               check("unexpected_output", 256'({o_ddr_rd_req, o_ddr_wr_req, o_rd_ack, o_wr_ack}), 256'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check("ddr_req", 256'({o_ddr_rd_req, o_ddr_wr_req}), 256'({mon_e.rd_req, mon_e.wr_req}));
               check("acks", 256'({o_rd_ack, o_wr_ack}), 256'({mon_e.rd_ack, mon_e.wr_ack}));
               if (mon_e.rd_req) check("rd_addr", 256'(o_ddr_rd_addr), 256'(mon_e.rd_addr));
               if (mon_e.wr_req) begin
                  check("wr_addr", 256'(o_ddr_wr_addr), 256'(mon_e.wr_addr));
                  check("wr_be_n", 256'(o_ddr_wr_be_n), 256'(mon_e.be_n));
                  check("wr_data", o_ddr_wr_data, mon_e.wr_data);
               end
               check("rd_valid", 256'(o_rd_data_valid), 256'(mon_e.rd_valid));
               if (mon_e.dv) check("rd_data", o_rd_data, mon_e.rd_data);
               check("tag_err", 256'(o_tag_err), 256'(mon_e.tag_err));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      i_rd_req = 4'hF; i_wr_req = 4'hF;
      i_ddr_rd_ack = 1'b1; i_ddr_wr_ack = 1'b1; i_ddr_rd_data_valid = 1'b1;
      repeat (3) @(posedge i_ddr_clk);
      #1;
      check("reset_outputs", 256'({o_ddr_rd_req, o_ddr_wr_req, o_rd_ack, o_wr_ack, o_rd_data_valid, o_tag_err}), 256'(0));
      i_rd_req = '0; i_wr_req = '0;
      i_ddr_rd_ack = 1'b0; i_ddr_wr_ack = 1'b0; i_ddr_rd_data_valid = 1'b0;
      @(negedge i_ddr_clk);
      i_rst = 1'b0;

      // Data beat with nothing outstanding: dropped and sticky error.
      drive_cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      drive_cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      check("tag_err_set", 256'(o_tag_err), 256'(1));
      drive_cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      check("tag_err_sticky", 256'(o_tag_err), 256'(1));

      grant_log.delete();
      repeat (10) drive_cycle(4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      settle();
      check("rr_grant_count", 256'(grant_log.size() >= 5), 256'(1));
      if (grant_log.size() >= 5) begin
         check("rr_order0", 256'(grant_log[0]), 256'(0));
         check("rr_order1", 256'(grant_log[1]), 256'(1));
         check("rr_order2", 256'(grant_log[2]), 256'(2));
         check("rr_order3", 256'(grant_log[3]), 256'(3));
         check("rr_order4", 256'(grant_log[4]), 256'(0));
      end
      drain();
      settle();

      repeat (3) drive_cycle(4'h4, 4'h4, 1'b1, 1'b1, 1'b0);
      repeat (3) drive_cycle(4'h4, 4'h0, 1'b1, 1'b1, 1'b0);
      settle();
      drain();
      settle();

      grant_log.delete();
      repeat (40) drive_cycle(4'h1, 4'h0, 1'b1, 1'b0, 1'b0);
      repeat (6)  drive_cycle(4'h1, 4'h2, 1'b1, 1'b1, 1'b0);
      check("full_fifo_reads", 256'(grant_log.size()), 256'(16));
      settle();
      drain();
      settle();

      repeat (2) drive_cycle(4'h8, 4'h0, 1'b1, 1'b0, 1'b0);
      repeat (2) drive_cycle(4'h1, 4'h0, 1'b1, 1'b0, 1'b0);
      settle();
      repeat (4) drive_cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      settle();

      repeat (2500) begin
         drive_cycle(4'($urandom() & $urandom()), 4'($urandom() & $urandom() & $urandom()),
                     1'($urandom() % 2), 1'($urandom() % 2), 1'($urandom() % 5 < 2));
      end
      settle();

      for (int t = 0; t < 20 && !(m_kind == 2 && m_beats == 1); t++)
         drive_cycle(4'h0, 4'h2, 1'b1, 1'b1, 1'b0);
      check("reach_wr_second", 256'(m_kind == 2 && m_beats == 1), 256'(1));
      @(posedge i_ddr_clk);
      #1;
      i_wr_req = 4'h2; i_ddr_wr_ack = 1'b1; i_ddr_rd_ack = 1'b1; i_ddr_rd_data_valid = 1'b1;
      check("wr_second_active", 256'({o_ddr_wr_req, o_wr_ack}), 256'({1'b1, 4'b0010}));
      #2;
      i_rst = 1'b1;
      #1;
      check("reset_mid_write", 256'({o_ddr_rd_req, o_ddr_wr_req, o_rd_ack, o_wr_ack, o_rd_data_valid, o_tag_err}), 256'(0));
      model_reset();
      exp_q.delete();
      repeat (2) @(posedge i_ddr_clk);
      i_rd_req = '0; i_wr_req = '0;
      i_ddr_rd_ack = 1'b0; i_ddr_wr_ack = 1'b0; i_ddr_rd_data_valid = 1'b0;
      @(negedge i_ddr_clk);
      i_rst = 1'b0;

      grant_log.delete();
      repeat (6) drive_cycle(4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      check("post_reset_grants", 256'(grant_log.size() >= 1), 256'(1));
      if (grant_log.size() >= 1) check("post_reset_first_port", 256'(grant_log[0]), 256'(0));
      settle();
      @(negedge i_ddr_clk);
      #1;
      check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
